// File: rtl/dct_postfft_twiddle_if.sv
// Avalon-ST sink/source bundle for the post-FFT twiddle stage.
// slave = the twiddle block itself, master = whatever feeds and drains it.
interface dct_postfft_twiddle_if #(
  parameter int wDataIn  = 16,
  parameter int wDataOut = 17
);
  logic                       sink_valid;
  logic                       sink_ready;
  logic [1:0]                 sink_error;
  logic                       sink_sop;
  logic                       sink_eop;
  logic signed [wDataIn-1:0]  sink_real;
  logic signed [wDataIn-1:0]  sink_imag;
  logic [11:0]                fftpts_in;
  logic                       source_valid;
  logic                       source_ready;
  logic [1:0]                 source_error;
  logic                       source_sop;
  logic                       source_eop;
  logic signed [wDataOut-1:0] source_real;
  logic [11:0]                fftpts_out;

  modport slave (
    input  sink_valid, sink_error, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
    input  source_ready,
    output sink_ready,
    output source_valid, source_error, source_sop, source_eop, source_real, fftpts_out
  );

  modport master (
    output sink_valid, sink_error, sink_sop, sink_eop, sink_real, sink_imag, fftpts_in,
    output source_ready,
    input  sink_ready,
    input  source_valid, source_error, source_sop, source_eop, source_real, fftpts_out
  );
endinterface

// File: rtl/dct_postfft_twiddle.sv
// Post-FFT twiddle of an FFT-based DCT: y[k] = Xr*cos(pi*k/2N) + Xi*sin(pi*k/2N).
// Four-stage pipeline (address, ROM, multiply, round), frozen as a whole while source_ready is low.
module dct_postfft_twiddle #(
  parameter int wDataIn  = 16,
  parameter int wTwid    = 16,
  parameter int wDataOut = 17
) (
  input logic                  clk,
  input logic                  rst_sync,
  dct_postfft_twiddle_if.slave bus
);

  localparam int  PW        = wDataIn + wTwid;
  localparam int  ROM_DEPTH = 2048;
  localparam real PI        = 3.14159265358979323846;
  localparam real SCALE     = 2.0 ** (wTwid - 1);
  localparam int  QMAX      = (1 << (wTwid - 1)) - 1;
  localparam logic signed [PW:0] HALF = {{(PW - wTwid + 2){1'b0}}, 1'b1, {(wTwid - 2){1'b0}}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Twiddle ROM: entry a = {cos, sin}(pi*a/4096), 1.0 saturated to QMAX.
  logic signed [wTwid-1:0] cos_tab [ROM_DEPTH];
  logic signed [wTwid-1:0] sin_tab [ROM_DEPTH];

  for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_rom
    localparam real ANG  = PI * a / 4096.0;
    localparam int  CRAW = $rtoi($cos(ANG) * SCALE + 0.5);
    localparam int  SRAW = $rtoi($sin(ANG) * SCALE + 0.5);
    localparam int  CQ   = (CRAW > QMAX) ? QMAX : CRAW;
    localparam int  SQ   = (SRAW > QMAX) ? QMAX : SRAW;
    assign cos_tab[a] = CQ[wTwid-1:0];
    assign sin_tab[a] = SQ[wTwid-1:0];
  end

  logic        en;
  logic        accept;
  logic        in_vld;
  logic        sop_err;
  logic        len_err;
  logic [0:0]  state;
  logic [10:0] k;
  logic [3:0]  shift;
  logic [3:0]  shift_nxt;
  logic [11:0] fftpts_q;
  logic [11:0] n_last;

  assign en             = bus.source_ready;
  assign bus.sink_ready = bus.source_ready;
  assign accept         = bus.sink_valid & en;
  assign in_vld         = accept & (bus.sink_sop | (state == RUN));
  assign n_last         = fftpts_q - 12'd1;
  assign sop_err        = bus.sink_sop & (state == RUN);
  // A sop beat is k=0, so an eop on it can never be the last of a legal frame.
  assign len_err        = bus.sink_eop & (bus.sink_sop | ({1'b0, k} != n_last));
  assign bus.fftpts_out = fftpts_q;

  always_comb begin
    shift_nxt = 4'd0;
    for (int b = 0; b < 12; b++) begin
      if (bus.fftpts_in[b]) shift_nxt = 4'(11 - b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state    <= IDLE;
      k        <= '0;
      shift    <= '0;
      fftpts_q <= '0;
    end else if (accept) begin
      if (bus.sink_sop) begin
        k        <= 11'd1;
        shift    <= shift_nxt;
        fftpts_q <= bus.fftpts_in;
        state    <= bus.sink_eop ? IDLE : RUN;
      end else if (state == RUN) begin
        k <= k + 11'd1;
        if (bus.sink_eop) state <= IDLE;
      end
    end
  end

  // Pipeline control: valid and framing flags, gated with valid so bubbles carry no flags.
  logic       s0_vld, s1_vld, s2_vld;
  logic       s0_sop, s1_sop, s2_sop;
  logic       s0_eop, s1_eop, s2_eop;
  logic [1:0] s0_err, s1_err, s2_err;

  logic                       out_vld;
  logic                       out_sop;
  logic                       out_eop;
  logic [1:0]                 out_err;
  logic signed [wDataOut-1:0] out_real;

  logic signed [PW:0] acc;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      s0_vld   <= 1'b0;
      s0_sop   <= 1'b0;
      s0_eop   <= 1'b0;
      s0_err   <= '0;
      s1_vld   <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_err   <= '0;
      s2_vld   <= 1'b0;
      s2_sop   <= 1'b0;
      s2_eop   <= 1'b0;
      s2_err   <= '0;
      out_vld  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_err  <= '0;
      out_real <= '0;
    end else if (en) begin
      s0_vld   <= in_vld;
      s0_sop   <= in_vld & bus.sink_sop;
      s0_eop   <= in_vld & bus.sink_eop;
      s0_err   <= {2{in_vld}} & (bus.sink_error | {len_err, sop_err});
      s1_vld   <= s0_vld;
      s1_sop   <= s0_sop;
      s1_eop   <= s0_eop;
      s1_err   <= s0_err;
      s2_vld   <= s1_vld;
      s2_sop   <= s1_sop;
      s2_eop   <= s1_eop;
      s2_err   <= s1_err;
      out_vld  <= s2_vld;
      out_sop  <= s2_sop;
      out_eop  <= s2_eop;
      out_err  <= s2_err;
      out_real <= wDataOut'(acc >>> (wTwid - 1));
    end
  end

  // Datapath: no reset needed, qualified by the valid bits above.
  logic        [10:0]        rom_addr;
  logic signed [wDataIn-1:0] s0_xr, s0_xi, s1_xr, s1_xi;
  logic signed [wTwid-1:0]   rom_cos, rom_sin;
  logic signed [PW-1:0]      s2_pr, s2_pi;

  always_ff @(posedge clk) begin
    if (en) begin
      s0_xr    <= bus.sink_real;
      s0_xi    <= bus.sink_imag;
      rom_addr <= bus.sink_sop ? '0 : (k << shift);
      s1_xr    <= s0_xr;
      s1_xi    <= s0_xi;
      rom_cos  <= cos_tab[rom_addr];
      rom_sin  <= sin_tab[rom_addr];
      s2_pr    <= s1_xr * rom_cos;
      s2_pi    <= s1_xi * rom_sin;
    end
  end

  // One guard bit: |pr + pi| can reach 2^(PW-1), round half-up before the shift.
  assign acc = s2_pr + s2_pi + HALF;

  assign bus.source_valid = out_vld;
  assign bus.source_sop   = out_sop;
  assign bus.source_eop   = out_eop;
  assign bus.source_error = out_err;
  assign bus.source_real  = out_real;

endmodule
